// File: rtl/no_border_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : no_border_stream_ctrl
// Purpose  : Upstream control unit for no_border_scheme_mask. Accepts a raster
//            pixel stream (valid/ready), forwards registered pixels to the mask,
//            tracks row/col and flags cycles where the mask output holds a full
//            in-image window, together with that window's centre coordinate.
//            One frame is sequenced per accepted start pulse.
// Options  : `define WIN_CNT_EN adds the win_count output (windows in frame).
// Revision : 1.0 - initial release
// ============================================================================
module no_border_stream_ctrl #(
  parameter int ROW_WIDTH  = 100,
  parameter int COL_HEIGHT = 100,
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7,
  parameter int MASK_LAT   = 1,
  localparam int CW = $clog2(ROW_WIDTH),
  localparam int RW = $clog2(COL_HEIGHT)
`ifdef WIN_CNT_EN
  , localparam int WCW = $clog2(ROW_WIDTH*COL_HEIGHT+1)
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               src_valid,
  input  logic [PIX_BIT-1:0] src_pix,
  output logic               src_ready,
  output logic               busy,
  output logic               ctrl2buf_valid,
  output logic [PIX_BIT-1:0] data_cu2bufcf,
  output logic               win_valid,
  output logic [RW-1:0]      win_row,
  output logic [CW-1:0]      win_col,
  output logic               frame_done
`ifdef WIN_CNT_EN
  , output logic [WCW-1:0]   win_count
`endif
);

  localparam int H  = (MASK_WIDTH - 1) / 2;
  localparam int DW = $clog2(MASK_LAT + 1);

  localparam logic [CW-1:0] c_COL_LAST  = CW'(ROW_WIDTH - 1);
  localparam logic [RW-1:0] c_ROW_LAST  = RW'(COL_HEIGHT - 1);
  localparam logic [CW-1:0] c_COL_QMIN  = CW'(MASK_WIDTH - 1);
  localparam logic [RW-1:0] c_ROW_QMIN  = RW'(MASK_WIDTH - 1);
  localparam logic [CW-1:0] c_COL_HALF  = CW'(H);
  localparam logic [RW-1:0] c_ROW_HALF  = RW'(H);
  localparam logic [DW-1:0] c_DRAIN_END = DW'(MASK_LAT);
  localparam logic [DW-1:0] c_FD_AT     = DW'(MASK_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [DW-1:0]      r_dcnt;
  logic               r_src_ready;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_c2b_valid;
  logic [PIX_BIT-1:0] r_c2b_data;
  logic               r_pq [MASK_LAT];
  logic [RW-1:0]      r_pr [MASK_LAT];
  logic [CW-1:0]      r_pc [MASK_LAT];
  logic               r_win_valid;
  logic [RW-1:0]      r_win_row;
  logic [CW-1:0]      r_win_col;

  logic               w_xfer;
  logic               w_last;
  logic               w_q;
  logic [RW-1:0]      w_wrow;
  logic [CW-1:0]      w_wcol;

  assign w_xfer = src_valid & r_src_ready;
  assign w_last = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  // Window is complete only once MASK_WIDTH rows and columns have arrived;
  // columns below that belong to windows wrapping across a row edge.
  assign w_q    = (r_row >= c_ROW_QMIN) && (r_col >= c_COL_QMIN);
  assign w_wrow = w_q ? (r_row - c_ROW_HALF) : '0;
  assign w_wcol = w_q ? (r_col - c_COL_HALF) : '0;

  // Frame sequencer: IDLE -> STREAM (count pixels) -> DRAIN (flush latency).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_dcnt       <= '0;
      r_src_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_STREAM;
            r_row       <= '0;
            r_col       <= '0;
            r_src_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state     <= S_DRAIN;
              r_src_ready <= 1'b0;
              r_dcnt      <= '0;
            end else if (r_col == c_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == c_FD_AT) begin
            r_frame_done <= 1'b1;
          end
          if (r_dcnt == c_DRAIN_END) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_src_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Forward each accepted pixel to the mask one cycle later; data holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c2b_valid <= 1'b0;
      r_c2b_data  <= '0;
    end else begin
      r_c2b_valid <= w_xfer;
      if (w_xfer) begin
        r_c2b_data <= src_pix;
      end
    end
  end

  // Delay window qualifier/centre to line up with the mask's output latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MASK_LAT; i++) begin
        r_pq[i] <= 1'b0;
        r_pr[i] <= '0;
        r_pc[i] <= '0;
      end
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_pq[0] <= w_xfer & w_q;
      r_pr[0] <= w_wrow;
      r_pc[0] <= w_wcol;
      for (int i = 1; i < MASK_LAT; i++) begin
        r_pq[i] <= r_pq[i-1];
        r_pr[i] <= r_pr[i-1];
        r_pc[i] <= r_pc[i-1];
      end
      r_win_valid <= r_pq[MASK_LAT-1];
      if (r_pq[MASK_LAT-1]) begin
        r_win_row <= r_pr[MASK_LAT-1];
        r_win_col <= r_pc[MASK_LAT-1];
      end
    end
  end

`ifdef WIN_CNT_EN
  logic [WCW-1:0] r_win_count;

  // Count windows presented this frame; counts the current window in its own cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_win_count <= '0;
    end else if (r_pq[MASK_LAT-1]) begin
      r_win_count <= r_win_count + 1'b1;
    end
  end

  assign win_count = r_win_count;
`endif

  assign src_ready      = r_src_ready;
  assign busy           = r_busy;
  assign ctrl2buf_valid = r_c2b_valid;
  assign data_cu2bufcf  = r_c2b_data;
  assign win_valid      = r_win_valid;
  assign win_row        = r_win_row;
  assign win_col        = r_win_col;
  assign frame_done     = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_no_border_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_no_border_stream_ctrl
// Purpose  : Scoreboard bench for no_border_stream_ctrl (10x8 frame, 7x7 mask).
// Revision : 1.0 - initial release
// ============================================================================
module tb_no_border_stream_ctrl;

  localparam int RWD  = 10;
  localparam int CHT  = 8;
  localparam int PB   = 8;
  localparam int MW   = 7;
  localparam int LAT  = 1;
  localparam int H    = (MW - 1) / 2;
  localparam int NPIX = RWD * CHT;
  localparam int NWIN = (RWD - 2*H) * (CHT - 2*H);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [PB-1:0] src_pix = '0;
  logic          src_ready, busy, ctrl2buf_valid, win_valid, frame_done;
  logic [PB-1:0] data_cu2bufcf;
  logic [2:0]    win_row;
  logic [3:0]    win_col;
`ifdef WIN_CNT_EN
  logic [6:0]    win_count;
`endif

  no_border_stream_ctrl #(
    .ROW_WIDTH(RWD), .COL_HEIGHT(CHT), .PIX_BIT(PB), .MASK_WIDTH(MW), .MASK_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid), .src_pix(src_pix),
    .src_ready(src_ready), .busy(busy), .ctrl2buf_valid(ctrl2buf_valid),
    .data_cu2bufcf(data_cu2bufcf), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
`ifdef WIN_CNT_EN
    , .win_count(win_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int a; int b; } ev_t;
  ev_t pixq[$];
  ev_t winq[$];
  int  fdq[$];

  int cyc = 0;
  int m_idx = 0;
  int m_busy_end = -1;
  bit m_stream = 1'b0;
  int m_wcnt = 0;
  int mr, mc;
  int last_pix = 0, last_wr = 0, last_wc = 0;
  int seen_pix = 0, seen_win = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
  endtask

  // Reference model: frame index -> (row, col) by division; windows per rule.
  always @(posedge clk) begin
    if (reset) begin
      if (!m_stream && (cyc > m_busy_end)) begin
        if (start) begin
          m_stream = 1'b1;
          m_idx    = 0;
          m_wcnt   = 0;
        end
      end else if (m_stream && src_valid) begin
        mr = m_idx / RWD;
        mc = m_idx % RWD;
        pixq.push_back('{cyc + 1, int'(src_pix), 0});
        if (mr >= MW - 1 && mc >= MW - 1)
          winq.push_back('{cyc + 1 + LAT, mr - H, mc - H});
        m_idx++;
        if (m_idx == NPIX) begin
          m_stream   = 1'b0;
          m_busy_end = cyc + 1 + LAT;
          fdq.push_back(cyc + 1 + LAT);
        end
      end
    end
    cyc++;
  end

  // Monitor: compares DUT outputs against scoreboard every cycle.
  always @(negedge clk) begin : mon
    bit   e;
    ev_t  ev;
    chk("src_ready", src_ready, int'(m_stream));
    chk("busy", busy, int'(m_stream || (cyc <= m_busy_end)));

    e = (pixq.size() > 0) && (pixq[0].cyc == cyc);
    chk("ctrl2buf_valid", ctrl2buf_valid, int'(e));
    if (ctrl2buf_valid) seen_pix++;
    if (e) begin
      ev = pixq.pop_front();
      last_pix = ev.a;
    end
    chk("data_cu2bufcf", int'(data_cu2bufcf), last_pix);

    e = (winq.size() > 0) && (winq[0].cyc == cyc);
    chk("win_valid", win_valid, int'(e));
    if (win_valid) seen_win++;
    if (e) begin
      ev = winq.pop_front();
      last_wr = ev.a;
      last_wc = ev.b;
      m_wcnt++;
    end
    chk("win_row", int'(win_row), last_wr);
    chk("win_col", int'(win_col), last_wc);

    e = (fdq.size() > 0) && (fdq[0] == cyc);
    chk("frame_done", frame_done, int'(e));
    if (e) void'(fdq.pop_front());
`ifdef WIN_CNT_EN
    chk("win_count", int'(win_count), m_wcnt);
`endif
  end

  task automatic do_reset();
    #2;
    reset = 1'b0;
    src_valid = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_src_ready", src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl2buf_valid", ctrl2buf_valid, 0);
    chk("rst_data", int'(data_cu2bufcf), 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", int'(win_row), 0);
    chk("rst_win_col", int'(win_col), 0);
    chk("rst_frame_done", frame_done, 0);
    pixq.delete();
    winq.delete();
    fdq.delete();
    m_stream = 1'b0;
    m_busy_end = -1;
    m_idx = 0;
    m_wcnt = 0;
    last_pix = 0;
    last_wr = 0;
    last_wc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // mode 0: continuous valid; 1: alternating; 2: random gaps.
  task automatic run_frame(input int mode, input int pulse_at, input bit pulse_drain, input int rst_at);
    bit pulsed = 1'b0;
    bit tog = 1'b1;
    int guard = 0;
    seen_pix = 0;
    seen_win = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (m_stream && guard < 1000) begin
      guard++;
      if (rst_at >= 0 && m_idx == rst_at) begin
        do_reset();
        return;
      end
      start = (pulse_at >= 0) && !pulsed && (m_idx == pulse_at);
      if (start) pulsed = 1'b1;
      case (mode)
        0:       src_valid = 1'b1;
        1:       begin src_valid = tog; tog = !tog; end
        default: src_valid = ($urandom_range(0, 3) != 0);
      endcase
      src_pix = PB'($urandom);
      @(negedge clk);
    end
    src_valid = 1'b0;
    start = 1'b0;
    if (guard >= 1000) timeout("stream_bound");
    if (pulse_drain) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (busy && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) timeout("drain_bound");
    chk("frame_pixels", seen_pix, NPIX);
    chk("frame_windows", seen_win, NWIN);
  endtask

  initial begin
    do_reset();
    run_frame(0, -1, 1'b0, -1);
    run_frame(1, -1, 1'b0, -1);
    run_frame(2, 30, 1'b1, -1);
    run_frame(0, -1, 1'b0, 40);
    run_frame(2, -1, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("pixq_empty", pixq.size(), 0);
    chk("winq_empty", winq.size(), 0);
    chk("fdq_empty", fdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time bound expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
